// File: rtl/status_led_pkg.sv
// Shared types for the status LED controller: channel modes, per-channel config
// record and the raw-mode decoder (PWM availability chosen by the caller).
package status_led_pkg;

    localparam int MODE_W    = 3;
    localparam int LED_CNT_W = 32;
    localparam int LED_PWM_W = 8;

    typedef enum logic [MODE_W-1:0] {
        LED_OFF   = 3'd0,
        LED_ON    = 3'd1,
        LED_BLINK = 3'd2,
        LED_COUNT = 3'd3,
        LED_PWM   = 3'd4
    } led_mode_e;

    typedef struct packed {
        led_mode_e              mode;
        logic [LED_CNT_W-1:0]   div;
        logic [LED_PWM_W-1:0]   duty;
    } led_ch_cfg_t;

    // Unknown codes (and PWM when it is not built in) collapse to OFF.
    function automatic led_mode_e mode_decode(input logic [MODE_W-1:0] raw,
                                              input logic pwm_en);
        led_mode_e m;
        case (raw)
            3'd0:    m = LED_OFF;
            3'd1:    m = LED_ON;
            3'd2:    m = LED_BLINK;
            3'd3:    m = LED_COUNT;
            3'd4:    m = pwm_en ? LED_PWM : LED_OFF;
            default: m = LED_OFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/status_led_div.sv
// Programmable divider: counts while en, wraps when the count reaches or passes div.
// tick is combinational and marks the edge on which the wrap happens; clr wins over tick.
module status_led_div #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    // ">=" so a divider shrunk below the running count still wraps next cycle.
    assign at_end = (cnt >= div);
    assign tick   = en && !clr && at_end;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/status_led_ctrl.sv
// NB_LED-channel status LED controller (off/on/blink/binary count/PWM) with alarm override.
// PWM mode is built only when STATUS_LED_PWM_EN is defined; otherwise mode 4 stores as OFF.
module status_led_ctrl
    import status_led_pkg::*;
#(
    parameter int               NB_LED      = 3,
    parameter int               CNT_W       = LED_CNT_W,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = 32'h017D7840,
    parameter int               PWM_W       = LED_PWM_W
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_en,
    input  logic                        i_alarm,
    input  logic                        i_cfg_valid,
    output logic                        o_cfg_ready,
    input  logic [$clog2(NB_LED+1)-1:0] i_cfg_ch,
    input  logic [MODE_W-1:0]           i_cfg_mode,
    input  logic [CNT_W-1:0]            i_cfg_div,
    input  logic [PWM_W-1:0]            i_cfg_duty,
    output logic [NB_LED-1:0]           o_led,
    output logic                        o_tick
);

    localparam int CH_W = $clog2(NB_LED+1);

`ifdef STATUS_LED_PWM_EN
    localparam logic PWM_EN = 1'b1;
`else
    localparam logic PWM_EN = 1'b0;
`endif

    logic              accept;
    logic              wr_glob;
    logic [NB_LED-1:0] wr_ch;
    logic [CNT_W-1:0]  g_div;
    logic              g_tick;
    logic [NB_LED-1:0] r_val;
    logic [NB_LED-1:0] val_next;
    led_ch_cfg_t       cfg [NB_LED];
    logic [NB_LED-1:0] ch_tick;
    logic [NB_LED-1:0] blink;
    logic [NB_LED-1:0] blink_next;
    logic [NB_LED-1:0] led_next;

    // Write port: a beat transfers on any edge where i_cfg_valid && o_cfg_ready;
    // ready is a registered !i_alarm, so the port closes one edge after alarm rises.
    assign accept  = i_cfg_valid && o_cfg_ready;
    assign wr_glob = accept && (i_cfg_ch == CH_W'(NB_LED));

    always_comb begin
        for (int i = 0; i < NB_LED; i++) begin
            wr_ch[i] = accept && (i_cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_cfg_ready <= 1'b0;
        end else begin
            o_cfg_ready <= !i_alarm;
        end
    end

    // Global divider drives the shared binary count and o_tick.
    status_led_div #(.CNT_W(CNT_W)) u_glob_div (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .en      (i_en),
        .clr     (wr_glob),
        .div     (g_div),
        .tick    (g_tick)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            g_div  <= DIV_DEFAULT;
            r_val  <= '0;
            o_tick <= 1'b0;
        end else begin
            if (wr_glob) begin
                g_div <= i_cfg_div;
            end
            r_val  <= val_next;
            o_tick <= g_tick;
        end
    end

    assign val_next = g_tick ? r_val + 1'b1 : r_val;

    genvar gi;
    generate
        for (gi = 0; gi < NB_LED; gi++) begin : g_ch
            status_led_div #(.CNT_W(CNT_W)) u_ch_div (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .en      (i_en),
                .clr     (wr_ch[gi]),
                .div     (CNT_W'(cfg[gi].div)),
                .tick    (ch_tick[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NB_LED; i++) begin
                cfg[i].mode <= LED_COUNT;
                cfg[i].div  <= LED_CNT_W'(DIV_DEFAULT);
                cfg[i].duty <= '0;
            end
        end else begin
            for (int i = 0; i < NB_LED; i++) begin
                if (wr_ch[i]) begin
                    cfg[i].mode <= mode_decode(i_cfg_mode, PWM_EN);
                    cfg[i].div  <= LED_CNT_W'(i_cfg_div);
`ifdef STATUS_LED_PWM_EN
                    cfg[i].duty <= LED_PWM_W'(i_cfg_duty);
`endif
                end
            end
        end
    end

    // A write to a channel clears its blink phase even if it ticks that cycle.
    always_comb begin
        for (int i = 0; i < NB_LED; i++) begin
            if (wr_ch[i]) begin
                blink_next[i] = 1'b0;
            end else if (ch_tick[i]) begin
                blink_next[i] = !blink[i];
            end else begin
                blink_next[i] = blink[i];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            blink <= '0;
        end else begin
            blink <= blink_next;
        end
    end

`ifdef STATUS_LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pwm_cnt <= '0;
        end else if (i_en) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end
`else
    logic unused_duty;

    always_comb begin
        unused_duty = ^i_cfg_duty;
        for (int i = 0; i < NB_LED; i++) begin
            unused_duty = unused_duty ^ (^cfg[i].duty);
        end
    end
`endif

    // COUNT and BLINK use next-state values so the LED moves on the same edge as the tick.
    always_comb begin
        for (int i = 0; i < NB_LED; i++) begin
            case (cfg[i].mode)
                LED_OFF:   led_next[i] = 1'b0;
                LED_ON:    led_next[i] = 1'b1;
                LED_BLINK: led_next[i] = blink_next[i];
                LED_COUNT: led_next[i] = val_next[i];
`ifdef STATUS_LED_PWM_EN
                LED_PWM:   led_next[i] = (pwm_cnt < PWM_W'(cfg[i].duty));
`endif
                default:   led_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_led <= '0;
        end else if (i_alarm) begin
            o_led <= '1;
        end else if (i_en) begin
            o_led <= led_next;
        end
    end

endmodule

// File: tb/tb_status_led_ctrl.sv
// Bench for status_led_ctrl (DIV_DEFAULT=4): cycle model feeds a scoreboard queue,
// plus directed checks on the legacy heartbeat, PWM share, alarm, global-tick collision and reset.
module tb_status_led_ctrl;

    localparam int NB  = 3;
    localparam int DIV = 4;
    localparam int W   = NB + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          alarm;
    logic          valid;
    logic          ready;
    logic [1:0]    ch;
    logic [2:0]    mode;
    logic [31:0]   div;
    logic [7:0]    duty;
    logic [NB-1:0] led;
    logic          tick;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    int            m_gcnt, m_gdiv, m_val, m_pwm;
    int            m_cnt[NB], m_div[NB], m_mode[NB], m_duty[NB];
    bit            m_blink[NB];
    logic [NB-1:0] m_led;
    bit            m_tick, m_ready;

    int tick_cnt;
    int hi_cnt;

    status_led_ctrl #(
        .NB_LED      (NB),
        .CNT_W       (32),
        .DIV_DEFAULT (32'd4),
        .PWM_W       (8)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_en        (en),
        .i_alarm     (alarm),
        .i_cfg_valid (valid),
        .o_cfg_ready (ready),
        .i_cfg_ch    (ch),
        .i_cfg_mode  (mode),
        .i_cfg_div   (div),
        .i_cfg_duty  (duty),
        .o_led       (led),
        .o_tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int decode(input int md);
        if (md <= 3) return md;
`ifdef STATUS_LED_PWM_EN
        if (md == 4) return 4;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_gcnt = 0; m_gdiv = DIV; m_val = 0; m_pwm = 0;
        for (int i = 0; i < NB; i++) begin
            m_cnt[i] = 0; m_div[i] = DIV; m_mode[i] = 3; m_duty[i] = 0; m_blink[i] = 0;
        end
        m_led = '0; m_tick = 0; m_ready = 0;
        exp_q.delete();
    endtask

    // One clock: advance the model with the pre-edge inputs, queue its outputs, compare.
    task automatic step();
        bit            acc, wg, gt;
        bit            wc[NB], ct[NB], nb[NB];
        int            nval;
        logic [NB-1:0] nled;
        logic [W-1:0]  want;
        @(posedge clk);
        acc  = valid && m_ready;
        wg   = acc && (ch == NB);
        gt   = en && !wg && (m_gcnt >= m_gdiv);
        nval = gt ? (m_val + 1) % (1 << NB) : m_val;
        for (int i = 0; i < NB; i++) begin
            wc[i] = acc && (ch == i);
            ct[i] = en && !wc[i] && (m_cnt[i] >= m_div[i]);
            nb[i] = wc[i] ? 1'b0 : (ct[i] ? !m_blink[i] : m_blink[i]);
        end
        nled = m_led;
        if (alarm) begin
            nled = '1;
        end else if (en) begin
            for (int i = 0; i < NB; i++) begin
                case (m_mode[i])
                    1:       nled[i] = 1'b1;
                    2:       nled[i] = nb[i];
                    3:       nled[i] = nval[i];
                    4:       nled[i] = (m_pwm < m_duty[i]);
                    default: nled[i] = 1'b0;
                endcase
            end
        end
        m_led  = nled;
        m_tick = gt;
        m_val  = nval;
        if (wg) m_gcnt = 0;
        else if (en) m_gcnt = (m_gcnt >= m_gdiv) ? 0 : m_gcnt + 1;
        for (int i = 0; i < NB; i++) begin
            m_blink[i] = nb[i];
            if (wc[i]) m_cnt[i] = 0;
            else if (en) m_cnt[i] = (m_cnt[i] >= m_div[i]) ? 0 : m_cnt[i] + 1;
        end
        if (en) m_pwm = (m_pwm + 1) % 256;
        if (wg) m_gdiv = int'(div);
        for (int i = 0; i < NB; i++) begin
            if (wc[i]) begin
                m_mode[i] = decode(int'(mode));
                m_div[i]  = int'(div);
`ifdef STATUS_LED_PWM_EN
                m_duty[i] = int'(duty);
`endif
            end
        end
        m_ready = !alarm;
        exp_q.push_back({m_led, m_tick, m_ready});
        #1;
        want = exp_q.pop_front();
        check_eq("led_tick_ready", {led, tick, ready}, want);
        if (tick) tick_cnt++;
        if (led[0]) hi_cnt++;
    endtask

    task automatic cfg_write(input int c, input int md, input int dv, input int dt);
        valid = 1'b1; ch = 2'(c); mode = 3'(md); div = 32'(dv); duty = 8'(dt);
        step();
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; alarm = 1'b0; valid = 1'b0;
        ch = '0; mode = '0; div = '0; duty = '0;
        model_reset();
        #1;
        check_eq("rst_led", led, 0);
        check_eq("rst_tick", tick, 0);
        check_eq("rst_ready", ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // Legacy heartbeat: one step per 5 cycles, full wrap in 40.
        tick_cnt = 0;
        repeat (5) step();
        check_eq("hb_first_step", led, 3'b001);
        repeat (35) step();
        check_eq("hb_ticks_40", tick_cnt, 8);
        check_eq("hb_wrap_led", led, 3'b000);

        cfg_write(1, 2, 1, 0);
        repeat (20) step();

        // PWM share over any 256 consecutive cycles.
        cfg_write(0, 4, 7, 64);
        repeat (2) step();
        hi_cnt = 0;
        repeat (256) step();
`ifdef STATUS_LED_PWM_EN
        check_eq("pwm_high_cycles", hi_cnt, 64);
`else
        check_eq("pwm_high_cycles", hi_cnt, 0);
`endif

        // Enable low: outputs hold, writes still land.
        en = 1'b0;
        repeat (3) step();
        cfg_write(2, 1, 3, 0);
        repeat (6) step();
        en = 1'b1;
        repeat (4) step();

        // Alarm window with a write attempt while the port is closed.
        alarm = 1'b1;
        step();
        check_eq("alarm_led", led, 3'b111);
        check_eq("alarm_ready", ready, 0);
        step();
        cfg_write(2, 0, 0, 0);
        repeat (7) step();
        alarm = 1'b0;
        repeat (12) step();

        // Global write landing on a global tick suppresses that tick.
        for (int k = 0; k < 20 && m_gcnt < m_gdiv; k++) step();
        cfg_write(NB, 0, 0, 0);
        check_eq("gwr_no_tick", tick, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("div0_tick", tick, 1);
        end
        cfg_write(NB, 0, DIV, 0);

        for (int k = 0; k < 200; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            alarm = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) begin
                cfg_write($urandom_range(0, NB), $urandom_range(0, 7),
                          $urandom_range(0, 6), $urandom_range(0, 255));
            end else begin
                step();
            end
        end

        // Reset in the middle of a blink.
        en = 1'b1; alarm = 1'b0;
        cfg_write(NB, 0, DIV, 0);
        cfg_write(1, 2, 1, 0);
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_led", led, 0);
        check_eq("mid_rst_ready", ready, 0);
        check_eq("mid_rst_tick", tick, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick_cnt = 0;
        repeat (5) step();
        check_eq("post_rst_step", led, 3'b001);
        repeat (35) step();
        check_eq("post_rst_ticks", tick_cnt, 8);
        check_eq("post_rst_wrap", led, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
